ascon_decryption: RTL and testbench
===================================

# ascon_decryption

ASCON-128 authenticated decryption engine. It is the receive-side counterpart of the `encryption` block: it takes the same key, nonce and 40-bit associated data, plus a 40-bit ciphertext and 128-bit tag. It recomputes the tag and releases the 40-bit plaintext only when the tag verifies. It uses an iterative datapath of one permutation round per cycle, and exposes intermediate states so it can be cross-checked against the encryption block.

## Interface
- No parameters. Fixed ASCON-128 configuration: rate 64, pa = 12, pb = 6, IV = 0x80400c0600000000.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- decryption_start  in  1  start request, sampled in IDLE and DONE.
- key  in  128  K, big-endian.
- nonce  in  128  N, big-endian.
- ad  in  40  associated data, exactly one partial block.
- ct  in  40  ciphertext, exactly one partial block.
- tag  in  128  received tag.
- decryption_fin  out  1  result valid (level).
- pt  out  40  plaintext; 0 when the tag is invalid.
- tag_valid  out  1  computed tag == received tag.
- ini_stemp, ad_stemp, ct_stemp  out  320 each  state after init, after AD, after ciphertext absorption.

## Operation
- State S = {x0,x1,x2,x3,x4}, with x0 = S[319:256].
- Inputs are latched on start acceptance and are don't-care afterwards.
- Init: S = IV‖K‖N; apply p12; S ^= {192'b0, K}. Capture the result into ini_stemp.
- AD: x0 ^= {ad, 8'h80, 16'h0000}; apply p6; S ^= 320'h1 (domain separation). Capture into ad_stemp.
- Ciphertext (last partial block):
  - P = x0[63:24] ^ ct.
  - x0 = {ct, x0[23:0] ^ 24'h800000}.
  - Capture into ct_stemp.
- Finalize: x1‖x2 ^= K; apply p12; T = {x3,x4} ^ K.
- Result:
  - tag_valid = (T == tag).
  - pt = tag_valid ? P : 40'h0.
- Round r of pa uses round constant c_r from the 12-entry table 0xf0, 0xe1, 0xd2, 0xc3, 0xb4, 0xa5, 0x96, 0x87, 0x78, 0x69, 0x5a, 0x4b. Each round:
  - x2 ^= c_r.
  - 5-bit S-box applied bit-sliced.
  - Linear layer, rotations right:
    - x0: 19, 28
    - x1: 61, 39
    - x2: 1, 6
    - x3: 10, 17
    - x4: 7, 41
- pb uses table entries 6..11.
- FSM states: IDLE → INIT (12 cycles) → AD (6) → FINAL (12) → DONE.
  - IDLE → INIT on decryption_start.
  - DONE → INIT on decryption_start.
  - DONE otherwise holds.
- A 4-bit round counter counts 0..11 in INIT and FINAL, and 0..5 in AD. It is cleared at each phase transition.
- The post-permutation XORs and the next phase's absorption are applied combinationally on the last round cycle of each phase. There are no extra cycles.

## Timing
- Reset values:
  - All outputs 0: decryption_fin, tag_valid, pt, and all three stemps.
  - FSM = IDLE, counter = 0, S = 0.
- Edge 0 is the start-accepting edge: S loaded with IV‖K‖N, and decryption_fin cleared.
- INIT rounds occupy edges 1–12. ini_stemp and the AD absorption are registered at edge 12.
- AD rounds occupy edges 13–18. ad_stemp and ct_stemp are registered at edge 18.
- FINAL rounds occupy edges 19–30. At edge 30, pt, tag_valid and decryption_fin = 1 are registered.
- Latency is exactly 30 cycles from start acceptance to decryption_fin high.
- decryption_fin, pt, tag_valid and the stemps hold in DONE until the next start is accepted.
- decryption_start is ignored in INIT, AD and FINAL.
- Start held high continuously restarts at every DONE entry. The first cycle of DONE accepts it, so decryption_fin is high for one cycle.
- rst asserted mid-operation aborts immediately:
  - Everything returns to reset values.
  - No stale pt is ever output.
  - The first start after rst deasserts behaves as a fresh run.

## Structure
- Package ascon_pkg holds:
  - IV constant.
  - 12-entry round-constant table.
  - State width localparams (320, 64, 128).
  - FSM state enum.
  - Round counts PA = 12, PB = 6.
- Sub-module ascon_round: purely combinational, inputs 320-bit state and 8-bit constant, output 320-bit state. It is shared with the encryption block.
- The top level holds the FSM, counter, state register, input latches, absorption/finalize XORs and tag comparator.

## Test plan
- Known vector round-trip:
  - Stimulus: key b7234a4db9fb8b7c2aa5735ebef1180c, nonce 8ebb295da81c74b58306d4e8362e2242, ad 4153434f4e; ct and tag taken from encryption of pt 6173636f6e.
  - Required: pt = 6173636f6e, tag_valid = 1, decryption_fin exactly 30 cycles after start.
- Cross-check: with the same vector, ini_stemp and ad_stemp match the encryption block's ini_stemp and ad_stemp bit-exactly.
- Forgery: flip ct bit 0 → tag_valid = 0, pt = 40'h0. Separately, flip tag bit 127 → tag_valid = 0, pt = 0.
- Busy start: pulse decryption_start at cycles 5 and 20 of a run → no restart, fin still at cycle 30, results unchanged.
- Reset mid-run: assert rst at cycle 10 → all outputs 0 immediately. A new start after release yields the correct result after 30 cycles.
- Back-to-back: start in DONE with a forged tag → fin drops on the accepting edge, then rises 30 cycles later with tag_valid = 0 and pt = 0.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared ASCON-128 constants, round-constant table and FSM state type.
package ascon_pkg;

    localparam int unsigned STATE_W = 320;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned DATA_W  = 40;

    localparam int unsigned PA = 12;
    localparam int unsigned PB = 6;

    localparam logic [WORD_W-1:0] IV = 64'h80400c0600000000;

    // Entry 0 is the first round of pa; pb starts at entry PA - PB.
    localparam logic [11:0][7:0] RC = {
        8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
        8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
    };

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StAd,
        StFinal,
        StDone
    } ascon_state_e;

    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_decryption_if.sv
// Request/result bundle of the ASCON-128 decryption engine.
interface ascon_decryption_if;
    import ascon_pkg::*;

    logic               decryption_start;
    logic [KEY_W-1:0]   key;
    logic [KEY_W-1:0]   nonce;
    logic [DATA_W-1:0]  ad;
    logic [DATA_W-1:0]  ct;
    logic [KEY_W-1:0]   tag;
    logic               decryption_fin;
    logic [DATA_W-1:0]  pt;
    logic               tag_valid;
    logic [STATE_W-1:0] ini_stemp;
    logic [STATE_W-1:0] ad_stemp;
    logic [STATE_W-1:0] ct_stemp;

    modport master (
        output decryption_start, key, nonce, ad, ct, tag,
        input  decryption_fin, pt, tag_valid, ini_stemp, ad_stemp, ct_stemp
    );

    modport slave (
        input  decryption_start, key, nonce, ad, ct, tag,
        output decryption_fin, pt, tag_valid, ini_stemp, ad_stemp, ct_stemp
    );

endinterface

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant add, bit-sliced S-box, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [7:0]         i_rc,
    output logic [STATE_W-1:0] o_state
);

    logic [WORD_W-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [WORD_W-1:0] w_t0, w_t1, w_t2, w_t3, w_t4;

    // Substitution layer followed by per-word diffusion.
    always_comb begin
        w_x0 = i_state[5*WORD_W-1:4*WORD_W];
        w_x1 = i_state[4*WORD_W-1:3*WORD_W];
        w_x2 = i_state[3*WORD_W-1:2*WORD_W] ^ {56'h0, i_rc};
        w_x3 = i_state[2*WORD_W-1:WORD_W];
        w_x4 = i_state[WORD_W-1:0];

        w_x0 = w_x0 ^ w_x4;
        w_x4 = w_x4 ^ w_x3;
        w_x2 = w_x2 ^ w_x1;
        w_t0 = ~w_x0 & w_x1;
        w_t1 = ~w_x1 & w_x2;
        w_t2 = ~w_x2 & w_x3;
        w_t3 = ~w_x3 & w_x4;
        w_t4 = ~w_x4 & w_x0;
        w_x0 = w_x0 ^ w_t1;
        w_x1 = w_x1 ^ w_t2;
        w_x2 = w_x2 ^ w_t3;
        w_x3 = w_x3 ^ w_t4;
        w_x4 = w_x4 ^ w_t0;
        w_x1 = w_x1 ^ w_x0;
        w_x0 = w_x0 ^ w_x4;
        w_x3 = w_x3 ^ w_x2;
        w_x2 = ~w_x2;

        o_state = {
            w_x0 ^ ror64(w_x0, 19) ^ ror64(w_x0, 28),
            w_x1 ^ ror64(w_x1, 61) ^ ror64(w_x1, 39),
            w_x2 ^ ror64(w_x2, 1)  ^ ror64(w_x2, 6),
            w_x3 ^ ror64(w_x3, 10) ^ ror64(w_x3, 17),
            w_x4 ^ ror64(w_x4, 7)  ^ ror64(w_x4, 41)
        };
    end

endmodule

// File: rtl/ascon_decryption.sv
// ASCON-128 authenticated decryption, one permutation round per cycle.
module ascon_decryption
    import ascon_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ascon_decryption_if.slave bus
);

    ascon_state_e       r_state, w_state_next;
    logic [3:0]         r_cnt, w_rc_idx;
    logic               w_last, w_start, w_tag_ok;
    logic [STATE_W-1:0] r_s, w_round, w_ini, w_ad_abs, w_ad_st, w_ct_st, w_fin_in;
    logic [KEY_W-1:0]   r_key, r_tag, w_tag;
    logic [DATA_W-1:0]  r_ad, r_ct, r_p, r_pt, w_p;
    logic               r_fin, r_tag_valid;
    logic [STATE_W-1:0] r_ini_st, r_ad_st, r_ct_st;

    assign w_start  = bus.decryption_start;
    assign w_rc_idx = (r_state == StAd) ? r_cnt + 4'(PA - PB) : r_cnt;
    assign w_last   = (r_state == StAd) ? (r_cnt == 4'(PB - 1)) : (r_cnt == 4'(PA - 1));

    ascon_round u_round (
        .i_state (r_s),
        .i_rc    (RC[w_rc_idx]),
        .o_state (w_round)
    );

    // Phase-boundary transforms, folded into the last round cycle of each phase.
    assign w_ini    = w_round ^ {192'h0, r_key};
    assign w_ad_abs = {w_ini[STATE_W-1:4*WORD_W] ^ {r_ad, 8'h80, 16'h0000},
                       w_ini[4*WORD_W-1:0]};
    assign w_ad_st  = w_round ^ {{(STATE_W-1){1'b0}}, 1'b1};
    assign w_p      = w_ad_st[STATE_W-1:STATE_W-DATA_W] ^ r_ct;
    assign w_ct_st  = {r_ct, w_ad_st[STATE_W-DATA_W-1:4*WORD_W] ^ 24'h800000,
                       w_ad_st[4*WORD_W-1:0]};
    assign w_fin_in = w_ct_st ^ {{WORD_W{1'b0}}, r_key, {KEY_W{1'b0}}};
    assign w_tag    = w_round[KEY_W-1:0] ^ r_key;
    assign w_tag_ok = (w_tag == r_tag);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    // FSM next-state: start is only honoured when idle or done.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: if (w_start) w_state_next = StInit;
            StInit:         if (w_last)  w_state_next = StAd;
            StAd:           if (w_last)  w_state_next = StFinal;
            StFinal:        if (w_last)  w_state_next = StDone;
            default:                     w_state_next = StIdle;
        endcase
    end

    // Datapath: input latches, round counter, permutation state and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_s         <= '0;
            r_key       <= '0;
            r_tag       <= '0;
            r_ad        <= '0;
            r_ct        <= '0;
            r_p         <= '0;
            r_pt        <= '0;
            r_fin       <= 1'b0;
            r_tag_valid <= 1'b0;
            r_ini_st    <= '0;
            r_ad_st     <= '0;
            r_ct_st     <= '0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_start) begin
                        r_s   <= {IV, bus.key, bus.nonce};
                        r_key <= bus.key;
                        r_tag <= bus.tag;
                        r_ad  <= bus.ad;
                        r_ct  <= bus.ct;
                        r_cnt <= '0;
                        r_fin <= 1'b0;
                    end
                end
                StInit: begin
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                    r_s   <= w_last ? w_ad_abs : w_round;
                    if (w_last) r_ini_st <= w_ini;
                end
                StAd: begin
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                    r_s   <= w_last ? w_fin_in : w_round;
                    if (w_last) begin
                        r_ad_st <= w_ad_st;
                        r_ct_st <= w_ct_st;
                        r_p     <= w_p;
                    end
                end
                StFinal: begin
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                    r_s   <= w_round;
                    if (w_last) begin
                        r_tag_valid <= w_tag_ok;
                        r_pt        <= w_tag_ok ? r_p : '0;
                        r_fin       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.decryption_fin = r_fin;
    assign bus.pt             = r_pt;
    assign bus.tag_valid      = r_tag_valid;
    assign bus.ini_stemp      = r_ini_st;
    assign bus.ad_stemp       = r_ad_st;
    assign bus.ct_stemp       = r_ct_st;

endmodule

// File: tb/tb_ascon_decryption.sv
// Scoreboard bench for ascon_decryption against a table-driven ASCON-128 model.
module tb_ascon_decryption;

    typedef logic [0:4][63:0] st_t;  // element 0 is x0 (most significant)

    typedef struct packed {
        logic [319:0] ini;
        logic [319:0] ads;
        logic [319:0] cts;
        logic [39:0]  pt;
        logic         tv;
        logic [31:0]  acc;
    } exp_t;

    localparam logic [63:0] MODEL_IV = 64'h80400c0600000000;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    ascon_decryption_if dif ();

    ascon_decryption dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Permutation with S-box applied column by column through the lookup table.
    function automatic st_t perm(input st_t si, input int nr);
        st_t        x;
        logic [4:0] c;
        x = si;
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                c = SBOX[c];
                {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = c;
            end
            x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
            x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
            x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
            x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
            x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        end
        return x;
    endfunction

    // dec=0: data is plaintext, dout is ciphertext. dec=1: data is ciphertext.
    task automatic model(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                         input logic [39:0] data, input logic [127:0] t, input bit dec,
                         output exp_t e, output logic [39:0] dout, output logic [127:0] tout);
        st_t         s;
        logic [39:0] ctv;
        s = {MODEL_IV, k, n};
        s = perm(s, 12);
        s[3] ^= k[127:64];
        s[4] ^= k[63:0];
        e.ini = s;
        s[0] ^= {a, 8'h80, 16'h0000};
        s = perm(s, 6);
        s[4][0] = ~s[4][0];
        e.ads = s;
        dout = s[0][63:24] ^ data;
        ctv  = dec ? data : dout;
        s[0] = {ctv, s[0][23:0] ^ 24'h800000};
        e.cts = s;
        s[1] ^= k[127:64];
        s[2] ^= k[63:0];
        s = perm(s, 12);
        tout = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
        e.tv  = (tout == t);
        e.pt  = e.tv ? dout : 40'h0;
        e.acc = '0;
    endtask

    // Present a request, let the accepting edge pass, then scramble the inputs.
    task automatic issue(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                         input logic [39:0] c, input logic [127:0] t);
        exp_t         e;
        logic [39:0]  d;
        logic [127:0] tt;
        model(k, n, a, c, t, 1'b1, e, d, tt);
        @(negedge clk);
        dif.key = k; dif.nonce = n; dif.ad = a; dif.ct = c; dif.tag = t;
        dif.decryption_start = 1'b1;
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        dif.decryption_start = 1'b0;
        dif.key = {$urandom, $urandom, $urandom, $urandom};
        dif.nonce = {$urandom, $urandom, $urandom, $urandom};
        dif.ad = {$urandom, $urandom};
        dif.ct = {$urandom, $urandom};
        dif.tag = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_fin(input string nm);
        int n = 0;
        while (dif.decryption_fin !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (dif.decryption_fin !== 1'b1) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic pulse_start_busy();
        @(negedge clk);
        dif.key = {$urandom, $urandom, $urandom, $urandom};
        dif.tag = {$urandom, $urandom, $urandom, $urandom};
        dif.decryption_start = 1'b1;
        @(negedge clk);
        dif.decryption_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_fin"}, dif.decryption_fin, 0);
        chk({nm, "_pt"}, dif.pt, 0);
        chk({nm, "_tag_valid"}, dif.tag_valid, 0);
        chk({nm, "_ini"}, dif.ini_stemp, 0);
        chk({nm, "_ad"}, dif.ad_stemp, 0);
        chk({nm, "_ct"}, dif.ct_stemp, 0);
    endtask

    // Monitor: on each rising decryption_fin, pop and compare the oldest expectation.
    initial begin
        exp_t e;
        logic prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_fin = 1'b0;
            end else begin
                if (dif.decryption_fin === 1'b1 && !prev_fin) begin
                    if (q.size() == 0) begin
                        chk("unexpected_fin", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", 32'(cyc) - e.acc, 30);
                        chk("pt", dif.pt, e.pt);
                        chk("tag_valid", dif.tag_valid, e.tv);
                        chk("ini_stemp", dif.ini_stemp, e.ini);
                        chk("ad_stemp", dif.ad_stemp, e.ads);
                        chk("ct_stemp", dif.ct_stemp, e.cts);
                    end
                end
                prev_fin = dif.decryption_fin;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] k, n, t, tg;
        logic [39:0]  a, p, c;
        exp_t         e;
        logic [39:0]  p_hold;

        dif.decryption_start = 1'b0;
        dif.key = '0; dif.nonce = '0; dif.ad = '0; dif.ct = '0; dif.tag = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Known vector round trip.
        k = 128'hb7234a4db9fb8b7c2aa5735ebef1180c;
        n = 128'h8ebb295da81c74b58306d4e8362e2242;
        a = 40'h4153434f4e;
        p = 40'h6173636f6e;
        model(k, n, a, p, '0, 1'b0, e, c, tg);
        issue(k, n, a, c, tg);
        wait_fin("known");
        chk("known_pt", dif.pt, 40'h6173636f6e);
        chk("known_tag_valid", dif.tag_valid, 1);
        p_hold = dif.pt;
        repeat (3) @(negedge clk);
        chk("hold_fin", dif.decryption_fin, 1);
        chk("hold_pt", dif.pt, p_hold);

        // Forgeries.
        issue(k, n, a, c ^ 40'h1, tg);
        wait_fin("forge_ct");
        chk("forge_ct_pt", dif.pt, 0);
        chk("forge_ct_tag_valid", dif.tag_valid, 0);
        issue(k, n, a, c, tg ^ {1'b1, 127'h0});
        wait_fin("forge_tag");
        chk("forge_tag_pt", dif.pt, 0);
        chk("forge_tag_tag_valid", dif.tag_valid, 0);

        // Start pulses while busy must be ignored.
        issue(k, n, a, c, tg);
        repeat (3) @(negedge clk);
        pulse_start_busy();
        repeat (13) @(negedge clk);
        pulse_start_busy();
        wait_fin("busy");
        chk("busy_pt", dif.pt, 40'h6173636f6e);

        // Random vectors: valid, ct-forged and tag-forged.
        for (int i = 0; i < 8; i++) begin
            int mode;
            k = {$urandom, $urandom, $urandom, $urandom};
            n = {$urandom, $urandom, $urandom, $urandom};
            a = {$urandom, $urandom};
            p = {$urandom, $urandom};
            model(k, n, a, p, '0, 1'b0, e, c, tg);
            mode = $urandom_range(0, 2);
            if (mode == 1) c = c ^ (40'h1 << $urandom_range(0, 39));
            if (mode == 2) tg = tg ^ (128'h1 << $urandom_range(0, 127));
            issue(k, n, a, c, tg);
            wait_fin("random");
        end

        // Reset mid-run.
        k = 128'hb7234a4db9fb8b7c2aa5735ebef1180c;
        n = 128'h8ebb295da81c74b58306d4e8362e2242;
        a = 40'h4153434f4e;
        p = 40'h6173636f6e;
        model(k, n, a, p, '0, 1'b0, e, c, tg);
        issue(k, n, a, c, tg);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(k, n, a, c, tg);
        wait_fin("after_rst");
        chk("after_rst_pt", dif.pt, 40'h6173636f6e);

        // Back-to-back start from DONE with a forged tag.
        issue(k, n, a, c, tg ^ 128'h80);
        chk("b2b_fin_drop", dif.decryption_fin, 0);
        wait_fin("b2b");
        chk("b2b_tag_valid", dif.tag_valid, 0);
        chk("b2b_pt", dif.pt, 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
